operand_fetch_stage: RTL

//   Decode->execute pipeline stage that sits between the instruction decoder and the execute unit.
//   - Drives rs1/rs2 addresses into the general purpose register file.
//   - Captures the read data, bypasses same-cycle writeback and forces x0 to 0.
//   - Stalls on RAW hazards using a 32-entry pending-write scoreboard.
//   - Presents operands downstream on a valid/ready handshake.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/hazard_scoreboard.sv | 44 ++++
 rtl/operand_fetch_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants, instruction field positions and stage-state type.
package riscv_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned OPCODE_W   = 7;

    // Field positions inside a 32-bit RV32I instruction
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;

    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        READ  = 2'd1,
        READY = 2'd2
    } stage_state_e;

    // Stores and branches reuse the rd field as immediate bits; x0 is never a real write.
    function automatic logic writes_rd(input logic [OPCODE_W-1:0]   opcode,
                                       input logic [REG_ADDR_W-1:0] rd);
        return (opcode != OP_STORE) && (opcode != OP_BRANCH) && (rd != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
module hazard_scoreboard
    import riscv_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] lookup_addr1,
    input  logic [REG_ADDR_W-1:0] lookup_addr2,
    output logic                  lookup_busy1_c,
    output logic                  lookup_busy2_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clear first so a same-address set in the same cycle wins; x0 never tracked
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign lookup_busy1_c = busy_q[lookup_addr1];
    assign lookup_busy2_c = busy_q[lookup_addr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode->execute stage: register-file read, writeback bypass, RAW stall, valid/ready output.
module operand_fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    input  logic [WORD_SIZE-1:0]  in_pc,
    output logic [REG_ADDR_W-1:0] rf_read_addr1,
    output logic [REG_ADDR_W-1:0] rf_read_addr2,
    input  logic [WORD_SIZE-1:0]  rf_read_data1,
    input  logic [WORD_SIZE-1:0]  rf_read_data2,
    input  logic                  wb_write_en,
    input  logic [REG_ADDR_W-1:0] wb_write_addr,
    input  logic [WORD_SIZE-1:0]  wb_write_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSTR_W-1:0]    out_instr,
    output logic [WORD_SIZE-1:0]  out_pc,
    output logic [WORD_SIZE-1:0]  out_rs1_data,
    output logic [WORD_SIZE-1:0]  out_rs2_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we
);

    stage_state_e          state_q;
    stage_state_e          state_d;
    logic [INSTR_W-1:0]    instr_q;
    logic [WORD_SIZE-1:0]  pc_q;
    logic [WORD_SIZE-1:0]  rs1_q;
    logic [WORD_SIZE-1:0]  rs2_q;

    logic [REG_ADDR_W-1:0] rs1_addr_c;
    logic [REG_ADDR_W-1:0] rs2_addr_c;
    logic [REG_ADDR_W-1:0] rd_addr_c;
    logic [OPCODE_W-1:0]   opcode_c;
    logic                  rd_we_c;
    logic                  busy1_c;
    logic                  busy2_c;
    logic                  wb_hit1_c;
    logic                  wb_hit2_c;
    logic                  hazard_c;
    logic                  accept_c;
    logic                  fire_c;
    logic                  capture_c;
    logic [WORD_SIZE-1:0]  rs1_val_c;
    logic [WORD_SIZE-1:0]  rs2_val_c;

    assign rs1_addr_c = instr_q[RS1_LSB +: REG_ADDR_W];
    assign rs2_addr_c = instr_q[RS2_LSB +: REG_ADDR_W];
    assign rd_addr_c  = instr_q[RD_LSB +: REG_ADDR_W];
    assign opcode_c   = instr_q[OPCODE_LSB +: OPCODE_W];
    assign rd_we_c    = writes_rd(opcode_c, rd_addr_c);

    hazard_scoreboard u_scoreboard (
        .clock          (clock),
        .reset_n        (reset_n),
        .set_en         (fire_c && rd_we_c),
        .set_addr       (rd_addr_c),
        .clr_en         (wb_write_en),
        .clr_addr       (wb_write_addr),
        .lookup_addr1   (rs1_addr_c),
        .lookup_addr2   (rs2_addr_c),
        .lookup_busy1_c (busy1_c),
        .lookup_busy2_c (busy2_c)
    );

    // Operand resolution and hazard detection for the held instruction
    always_comb begin
        wb_hit1_c = wb_write_en && (wb_write_addr == rs1_addr_c);
        wb_hit2_c = wb_write_en && (wb_write_addr == rs2_addr_c);
        hazard_c  = (busy1_c && (rs1_addr_c != '0) && !wb_hit1_c) ||
                    (busy2_c && (rs2_addr_c != '0) && !wb_hit2_c);
        if (rs1_addr_c == '0) begin
            rs1_val_c = '0;
        end else if (wb_hit1_c) begin
            rs1_val_c = wb_write_data;
        end else begin
            rs1_val_c = rf_read_data1;
        end
        if (rs2_addr_c == '0) begin
            rs2_val_c = '0;
        end else if (wb_hit2_c) begin
            rs2_val_c = wb_write_data;
        end else begin
            rs2_val_c = rf_read_data2;
        end
    end

    // Stage state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (!hazard_c) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (out_ready) begin
                    state_d = accept_c ? READ : EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // Handshake decode from current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fire_c    = 1'b0;
        capture_c = 1'b0;
        if (reset_n && !flush) begin
            in_ready  = (state_q == EMPTY) || ((state_q == READY) && out_ready);
            fire_c    = (state_q == READY) && out_ready;
            capture_c = (state_q == READ) && !hazard_c;
        end
        out_valid = (state_q == READY);
        accept_c  = in_valid && in_ready;
    end

    // Held instruction and resolved operands
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else begin
            if (accept_c) begin
                instr_q <= in_instr;
                pc_q    <= in_pc;
            end
            if (capture_c) begin
                rs1_q <= rs1_val_c;
                rs2_q <= rs2_val_c;
            end
        end
    end

    assign rf_read_addr1 = rs1_addr_c;
    assign rf_read_addr2 = rs2_addr_c;
    assign out_instr     = instr_q;
    assign out_pc        = pc_q;
    assign out_rs1_data  = rs1_q;
    assign out_rs2_data  = rs2_q;
    assign out_rd        = rd_addr_c;
    assign out_rd_we     = rd_we_c;

endmodule
